// File: rtl/ifu_prefetch_pkg.sv
// ifu_prefetch_pkg: shared widths, reset PC and fetch step for the instruction prefetcher
package ifu_prefetch_pkg;
    localparam int CPU_PC_SIZE = 32;
    localparam int CPU_INSTR_SIZE = 32;
    localparam logic [CPU_PC_SIZE-1:0] CPU_PC_RST_IDX = 32'h8000_0000;
    localparam int IFU_FIFO_DEPTH = 4;
    localparam int CPU_INSTR_ALIGN = 4;
endpackage

// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: ROM request port and decode handshake of the fetch unit
interface ifu_prefetch_if
    import ifu_prefetch_pkg::*;
#(
    parameter int PC_W = CPU_PC_SIZE,
    parameter int INSTR_W = CPU_INSTR_SIZE
);
    logic fetch_en_i;
    logic [PC_W-1:0] rom_idx_o;
    logic [INSTR_W-1:0] rom_data_i;
    logic redirect_i;
    logic [PC_W-1:0] redirect_pc_i;
    logic if_valid_o;
    logic id_ready_i;
    logic [PC_W-1:0] if_pc_o;
    logic [INSTR_W-1:0] if_instr_o;
    modport master (
        input fetch_en_i, rom_data_i, redirect_i, redirect_pc_i, id_ready_i,
        output rom_idx_o, if_valid_o, if_pc_o, if_instr_o
    );
    modport slave (
        output fetch_en_i, rom_data_i, redirect_i, redirect_pc_i, id_ready_i,
        input rom_idx_o, if_valid_o, if_pc_o, if_instr_o
    );
endinterface

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous prefetch FIFO with flush; head reads as zero when empty
module ifu_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_pop, do_push;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign do_pop = pop & ~empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign head = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: PC owner and ROM requester feeding decode through a prefetch FIFO
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int PC_W = CPU_PC_SIZE,
    parameter int INSTR_W = CPU_INSTR_SIZE,
    parameter logic [PC_W-1:0] PC_RST = PC_W'(CPU_PC_RST_IDX),
    parameter int DEPTH = IFU_FIFO_DEPTH
) (
    input logic clk,
    input logic rst_n,
    ifu_prefetch_if.master bus
);
    logic [PC_W-1:0] pc_q, pc_d;
    logic push, pop, full, empty;
    logic [PC_W+INSTR_W-1:0] head;
    assign bus.rom_idx_o = pc_q;
    assign bus.if_valid_o = ~empty;
    assign {bus.if_pc_o, bus.if_instr_o} = head;
    assign pop = ~empty & bus.id_ready_i;
    assign push = bus.fetch_en_i & ~bus.redirect_i & (~full | pop);
    // redirect targets are word aligned by clearing the low index bits
    always_comb
        pc_d = bus.redirect_i ? bus.redirect_pc_i & ~PC_W'(CPU_INSTR_ALIGN - 1)
             : push ? pc_q + PC_W'(CPU_INSTR_ALIGN)
             : pc_q;
    always_ff @(posedge clk) begin
        if (!rst_n) pc_q <= PC_RST;
        else pc_q <= pc_d;
    end
    ifu_fifo #(.W(PC_W + INSTR_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .flush(bus.redirect_i),
        .wdata({pc_q, bus.rom_data_i}),
        .full(full),
        .empty(empty),
        .head(head)
    );
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed per-cycle vectors against a synthetic ROM image
module tb_ifu_prefetch;
    localparam logic [31:0] R = 32'h8000_0000;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction
    ifu_prefetch_if #(.PC_W(32), .INSTR_W(32)) bus ();
    ifu_prefetch #(.PC_W(32), .INSTR_W(32), .PC_RST(R), .DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    assign bus.rom_data_i = rom_f(bus.rom_idx_o);
    // each row: inputs held for one cycle, expected outputs just after that edge
    typedef struct {
        logic rst, en, rd;
        logic [31:0] rpc;
        logic rdy, ev;
        logic [31:0] epc, eidx;
    } vec_t;
    vec_t v[$];
    int n_chk = 0;
    int n_fail = 0;
    function void add(input logic rst, en, rd, input logic [31:0] rpc, input logic rdy, ev,
                      input logic [31:0] epc, eidx);
        v.push_back('{rst, en, rd, rpc, rdy, ev, epc, eidx});
    endfunction
    task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    initial begin
        add(1, 1, 0, 0, 1, 0, 0, R);
        add(0, 1, 0, 0, 1, 1, R, R + 4);
        add(0, 1, 0, 0, 1, 1, R + 4, R + 8);
        add(0, 1, 0, 0, 1, 1, R + 8, R + 12);
        add(0, 1, 0, 0, 1, 1, R + 12, R + 16);
        add(1, 1, 0, 0, 0, 0, 0, R);
        for (int k = 1; k <= 10; k++) add(0, 1, 0, 0, 0, 1, R, R + 32'(4 * (k < 4 ? k : 4)));
        for (int k = 0; k <= 4; k++) add(0, 1, 0, 0, 1, 1, R + 4 + 32'(4 * k), R + 20 + 32'(4 * k));
        add(0, 1, 1, 32'h8000_0103, 1, 0, 0, 32'h8000_0100);
        add(0, 1, 0, 0, 1, 1, 32'h8000_0100, 32'h8000_0104);
        add(0, 1, 0, 0, 1, 1, 32'h8000_0104, 32'h8000_0108);
        add(0, 1, 1, 32'h40, 1, 0, 0, 32'h40);
        add(0, 1, 1, 32'h80, 1, 0, 0, 32'h80);
        add(0, 1, 0, 0, 1, 1, 32'h80, 32'h84);
        add(0, 1, 0, 0, 1, 1, 32'h84, 32'h88);
        add(0, 1, 1, 32'h200, 0, 0, 0, 32'h200);
        add(0, 1, 0, 0, 0, 1, 32'h200, 32'h204);
        add(0, 1, 0, 0, 0, 1, 32'h200, 32'h208);
        add(0, 1, 0, 0, 0, 1, 32'h200, 32'h20C);
        add(0, 0, 0, 0, 1, 1, 32'h204, 32'h20C);
        add(0, 0, 0, 0, 1, 1, 32'h208, 32'h20C);
        add(0, 0, 0, 0, 1, 0, 0, 32'h20C);
        add(0, 0, 0, 0, 1, 0, 0, 32'h20C);
        add(0, 1, 0, 0, 1, 1, 32'h20C, 32'h210);
        add(0, 1, 0, 0, 1, 1, 32'h210, 32'h214);
        add(0, 1, 1, 32'hFFFF_FFF8, 1, 0, 0, 32'hFFFF_FFF8);
        add(0, 1, 0, 0, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
        add(0, 1, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0);
        add(0, 1, 0, 0, 1, 1, 32'h0, 32'h4);
        add(0, 1, 0, 0, 1, 1, 32'h4, 32'h8);
        add(1, 1, 1, 32'h300, 1, 0, 0, R);
        add(0, 1, 0, 0, 1, 1, R, R + 4);
        for (int i = 0; i < v.size(); i++) begin
            rst_n = ~v[i].rst;
            bus.fetch_en_i = v[i].en;
            bus.redirect_i = v[i].rd;
            bus.redirect_pc_i = v[i].rpc;
            bus.id_ready_i = v[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d valid", i), 32'(bus.if_valid_o), 32'(v[i].ev));
            chk($sformatf("row%0d rom_idx", i), bus.rom_idx_o, v[i].eidx);
            if (v[i].ev || v[i].rst) begin
                chk($sformatf("row%0d if_pc", i), bus.if_pc_o, v[i].epc);
                chk($sformatf("row%0d if_instr", i), bus.if_instr_o, v[i].ev ? rom_f(v[i].epc) : 32'h0);
            end
        end
        rst_n = 1'b0;
        bus.redirect_i = 1'b0;
        bus.fetch_en_i = 1'b1;
        bus.id_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("no_bypass valid", 32'(bus.if_valid_o), 32'h0);
        chk("no_bypass rom_idx", bus.rom_idx_o, R);
        @(posedge clk);
        #1;
        chk("first_fetch valid", 32'(bus.if_valid_o), 32'h1);
        chk("first_fetch if_pc", bus.if_pc_o, R);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
